// File: rtl/seq_chunk_comparator.sv
// seq_chunk_comparator: multi-cycle MSB-first magnitude compare of two N-bit operands, CHUNK bits per clock.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              request a compare (captures a, b, signed_mode when idle)
//   signed_mode        1 = two's-complement ordering
//   a, b               operands
//   busy               compare in progress
//   done               one-cycle pulse when lesser/greater/equal update
//   lesser/greater/equal  registered result of the most recent compare
module seq_chunk_comparator #(
  parameter int N          = 8,
  parameter int CHUNK      = 2,
  parameter int EARLY_EXIT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         signed_mode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         lesser,
  output logic         greater,
  output logic         equal
);
  localparam int NCHUNK = N / CHUNK;
  localparam int IW     = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  typedef enum logic {IDLE, COMPARE} state_t;
  state_t         state, state_n;
  logic [N-1:0]   ra, rb, ra_n, rb_n, msb;
  logic [IW-1:0]  idx, idx_n;
  logic           found, found_n, dir, dir_n, done_n;
  logic [2:0]     res, res_n;
  logic [CHUNK-1:0] ca, cb;
  logic           neq, gt, fd, fg;
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign msb = {signed_mode, {(N-1){1'b0}}};
  // Operands shift left each cycle, so the chunk under test is always at the top.
  assign ca  = ra[N-1 -: CHUNK];
  assign cb  = rb[N-1 -: CHUNK];
  assign neq = ca != cb;
  assign gt  = ca > cb;
  // The first recorded difference is sticky; later chunks cannot change it.
  assign fd  = found | neq;
  assign fg  = found ? dir : gt;
  always_comb begin
    state_n = state;
    ra_n    = ra;
    rb_n    = rb;
    idx_n   = idx;
    found_n = found;
    dir_n   = dir;
    res_n   = res;
    done_n  = 1'b0;
    if (state == IDLE) begin
      if (start) begin
        ra_n    = a ^ msb;
        rb_n    = b ^ msb;
        idx_n   = IW'(NCHUNK - 1);
        found_n = 1'b0;
        dir_n   = 1'b0;
        state_n = COMPARE;
      end
    end else begin
      ra_n    = ra << CHUNK;
      rb_n    = rb << CHUNK;
      idx_n   = idx - IW'(1);
      found_n = fd;
      dir_n   = fg;
      if ((EARLY_EXIT != 0 && neq) || idx == '0) begin
        res_n   = fd ? (fg ? 3'b010 : 3'b100) : 3'b001;
        done_n  = 1'b1;
        state_n = IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      idx   <= '0;
      found <= 1'b0;
      dir   <= 1'b0;
      res   <= 3'b000;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      ra    <= ra_n;
      rb    <= rb_n;
      idx   <= idx_n;
      found <= found_n;
      dir   <= dir_n;
      res   <= res_n;
      done  <= done_n;
    end
  end
  assign busy = state == COMPARE;
  assign {lesser, greater, equal} = res;
endmodule

// File: tb/tb_seq_chunk_comparator.sv
// tb_seq_chunk_comparator: scoreboard bench for seq_chunk_comparator across four parameterisations.
module tb_seq_chunk_comparator;
  typedef struct {logic [2:0] r; int due;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] bz, dn;
  logic [2:0] r0, r1, r2, r3;
  logic st0, st1, st2, sm0, sm1, sm2;
  logic [7:0] a8, b8;
  logic [15:0] a16, b16;
  logic [31:0] a32, b32;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  exp_t q[4][$];
  logic [2:0] held[4];
  seq_chunk_comparator #(.N(8), .CHUNK(2), .EARLY_EXIT(1)) d8 (
    .clk(clk), .rst_n(rst_n), .start(st0), .signed_mode(sm0), .a(a8), .b(b8),
    .busy(bz[0]), .done(dn[0]), .lesser(r0[2]), .greater(r0[1]), .equal(r0[0]));
  seq_chunk_comparator #(.N(16), .CHUNK(4), .EARLY_EXIT(0)) d16 (
    .clk(clk), .rst_n(rst_n), .start(st1), .signed_mode(sm1), .a(a16), .b(b16),
    .busy(bz[1]), .done(dn[1]), .lesser(r1[2]), .greater(r1[1]), .equal(r1[0]));
  seq_chunk_comparator #(.N(32), .CHUNK(8), .EARLY_EXIT(1)) d32e (
    .clk(clk), .rst_n(rst_n), .start(st2), .signed_mode(sm2), .a(a32), .b(b32),
    .busy(bz[2]), .done(dn[2]), .lesser(r2[2]), .greater(r2[1]), .equal(r2[0]));
  seq_chunk_comparator #(.N(32), .CHUNK(8), .EARLY_EXIT(0)) d32c (
    .clk(clk), .rst_n(rst_n), .start(st2), .signed_mode(sm2), .a(a32), .b(b32),
    .busy(bz[3]), .done(dn[3]), .lesser(r3[2]), .greater(r3[1]), .equal(r3[0]));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void model(input int n, input int c, input bit ee, input logic [31:0] xi,
                                input logic [31:0] yi, input bit s, output logic [2:0] r, output int k);
    logic [31:0] m, x, y;
    longint sx, sy;
    m = (n == 32) ? 32'hFFFF_FFFF : (32'd1 << n) - 32'd1;
    x = xi & m;
    y = yi & m;
    sx = longint'(x);
    sy = longint'(y);
    if (s && x[n-1]) sx = sx - (longint'(1) << n);
    if (s && y[n-1]) sy = sy - (longint'(1) << n);
    r = sx < sy ? 3'b100 : sx > sy ? 3'b010 : 3'b001;
    k = n / c;
    if (ee)
      for (int i = n / c - 1; i >= 0; i--)
        if ((((x ^ y) >> (i * c)) & ((32'd1 << c) - 32'd1)) != 0) begin
          k = n / c - i;
          break;
        end
  endfunction
  task automatic cmp(input int id, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d at cycle %0d: got %0h, expected %0h", nm, id, cyc, act, exp);
    end
  endtask
  task automatic check(input int id, input logic b, input logic d, input logic [2:0] r);
    exp_t e;
    if (!rst_n) begin
      cmp(id, "reset_outputs", {b, d, r}, 0);
      held[id] = 3'b000;
      return;
    end
    cmp(id, "busy_done_exclusive", b & d, 0);
    if (d) begin
      if (q[id].size() == 0) begin
        cmp(id, "unexpected_done", 1, 0);
      end else begin
        e = q[id].pop_front();
        cmp(id, "result", r, e.r);
        cmp(id, "latency_cycle", cyc, e.due);
        cmp(id, "result_onehot", $countones(r), 1);
        held[id] = e.r;
      end
    end else begin
      cmp(id, "result_hold", r, held[id]);
    end
  endtask
  always @(negedge clk) begin
    check(0, bz[0], dn[0], r0);
    check(1, bz[1], dn[1], r1);
    check(2, bz[2], dn[2], r2);
    check(3, bz[3], dn[3], r3);
  end
  // Drives one compare request (called at a negedge); hold keeps start high one extra
  // cycle with scrambled operands, which the busy DUT must ignore.
  task automatic go(input int g, input logic [31:0] x, input logic [31:0] y, input bit s, input bit hold);
    logic [2:0] r;
    int k;
    if (g == 0) begin a8 = x[7:0]; b8 = y[7:0]; sm0 = s; st0 = 1'b1; end
    else if (g == 1) begin a16 = x[15:0]; b16 = y[15:0]; sm1 = s; st1 = 1'b1; end
    else begin a32 = x; b32 = y; sm2 = s; st2 = 1'b1; end
    @(posedge clk);
    #1;
    if (g == 0) begin
      model(8, 2, 1, x, y, s, r, k);
      q[0].push_back('{r, cyc + k});
    end else if (g == 1) begin
      model(16, 4, 0, x, y, s, r, k);
      q[1].push_back('{r, cyc + k});
    end else begin
      model(32, 8, 1, x, y, s, r, k);
      q[2].push_back('{r, cyc + k});
      model(32, 8, 0, x, y, s, r, k);
      q[3].push_back('{r, cyc + k});
    end
    if (hold) begin
      a8 = 8'h00; b8 = 8'hFF; a16 = 16'($urandom); b16 = 16'($urandom);
      a32 = $urandom; b32 = $urandom; sm0 = ~sm0; sm1 = ~sm1; sm2 = ~sm2;
      @(negedge clk);
    end
    @(negedge clk);
    st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
  endtask
  task automatic wait_done(input int id);
    for (int i = 0; i < 100; i++) begin
      if (dn[id]) return;
      @(negedge clk);
    end
    cmp(id, "done_timeout", 1, 0);
  endtask
  task automatic wait_idle(input logic [3:0] m);
    for (int i = 0; i < 100; i++) begin
      if ((bz & m) == 0) return;
      @(negedge clk);
    end
    cmp(0, "idle_timeout", bz & m, 0);
  endtask
  task automatic rand_run(input int g, input int n);
    logic [31:0] x, y;
    int sel;
    for (int i = 0; i < n; i++) begin
      x = $urandom;
      sel = $urandom_range(0, 3);
      y = sel == 0 ? x : sel == 1 ? x ^ ($urandom_range(1, 15) << (4 * $urandom_range(0, 7))) : $urandom;
      go(g, x, y, 1'($urandom), $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 2) == 0) wait_done(g == 2 ? 3 : g);
      else begin
        wait_idle(g == 2 ? 4'b1100 : 4'(1 << g));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
  endtask
  initial begin
    for (int i = 0; i < 4; i++) held[i] = 3'b000;
    a8 = 8'($urandom); b8 = 8'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
    a32 = $urandom; b32 = $urandom; st0 = 1'b1; st1 = 1'b1; st2 = 1'b1;
    sm0 = 1'b1; sm1 = 1'b0; sm2 = 1'b1;
    repeat (3) @(negedge clk);
    st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    go(0, 32'h12, 32'h34, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    q[0].delete();
    #1 cmp(0, "busy_abort", bz[0], 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    go(0, 32'h80, 32'h7F, 0, 0); wait_idle(4'b0001);
    go(0, 32'h05, 32'h06, 0, 0); wait_idle(4'b0001);
    go(0, 32'hA5, 32'hA5, 0, 0); wait_idle(4'b0001);
    go(0, 32'hFF, 32'h01, 1, 0); wait_idle(4'b0001);
    go(0, 32'h80, 32'h7F, 1, 0); wait_idle(4'b0001);
    go(0, 32'h80, 32'h7F, 0, 0); wait_idle(4'b0001);
    go(1, 32'h8000, 32'h0000, 0, 0); wait_idle(4'b0010);
    go(1, 32'h8001, 32'h0F02, 0, 0); wait_idle(4'b0010);
    go(1, 32'h0100, 32'h0F00, 0, 0); wait_idle(4'b0010);
    go(1, 32'h1234, 32'h1234, 1, 0); wait_idle(4'b0010);
    go(0, 32'h10, 32'h20, 0, 1);
    wait_done(0);
    go(0, 32'h33, 32'h33, 0, 0);
    wait_done(0);
    go(0, 32'hC3, 32'h3C, 1, 0);
    wait_idle(4'b0001);
    rand_run(0, 200);
    rand_run(1, 100);
    rand_run(2, 1000);
    wait_idle(4'b1111);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) cmp(i, "queue_drained", q[i].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
